bot_update_ctrl: RTL and testbench
==================================

Name: bot_update_ctrl

Overview:
Sequences the Rojobot register-update / CPU interrupt handshake. Detects each upd_sysregs event from the bot and latches a coherent snapshot of the 32-bit BotInfo word {LocX, LocY, Sensors, BotInfo}. Raises an interrupt request, then holds it until the CPU acknowledges through its GPIO INT_ACK line or a watchdog expires. Sits between rojobot31 outputs and the SweRVolf GPIO bot-info/interrupt inputs, replacing the ad-hoc set/clear flop; all inputs arrive already synchronized to clk.

Parameters:
TIMEOUT_CYCLES, 32'd0, clk cycles in PEND before auto-clear; 0 = watchdog disabled
CNT_W, 8, width of overrun counter (only with BOTUPD_OVERRUN_CNT_EN)

Ports:
clk  in  1  block clock
rst  in  1  asynchronous reset, active-high
i_enable  in  1  1 = handshake active; 0 = ignore events, force IDLE
i_upd_sysregs  in  1  bot update strobe, level, may stay high several cycles
i_bot_info  in  32  live {LocX,LocY,Sensors,BotInfo}
i_int_ack  in  1  CPU acknowledge, level
i_clr_flags  in  1  clears sticky o_overrun / o_timeout (and counter)
o_irq  out  1  interrupt request to CPU
o_bot_info_snap  out  32  snapshot captured at accepted event
o_upd_seq  out  8  increments on every captured snapshot, wraps 255->0
o_overrun  out  1  sticky: event arrived while PEND without ack
o_timeout  out  1  sticky: watchdog auto-cleared a request
o_busy  out  1  1 while in PEND

Behaviour:
- Async reset: state IDLE; o_irq=0, o_bot_info_snap=0, o_upd_seq=0, o_overrun=0, o_timeout=0, o_busy=0, edge flop=0, watchdog=0. Reset mid-PEND drops o_irq immediately.
- Event = rising edge of i_upd_sysregs: registered copy of the previous value, event = cur & ~prev. Level held high is one event only.
- States: IDLE, PEND. All outputs registered; 1-cycle latency from the event cycle to o_irq/snapshot.
- IDLE + event: snap<=i_bot_info, seq+1, o_irq<=1, go PEND, watchdog<=0.
- IDLE + i_int_ack without event: no effect.
- PEND + i_int_ack, no event: o_irq<=0, go IDLE.
- PEND + i_int_ack + event in same cycle: capture new snapshot, seq+1, o_irq stays 1, stay PEND, watchdog<=0. The new seq value distinguishes the request.
- PEND + event without ack: snapshot NOT updated, keeps coherency. o_overrun<=1; counter +1 if enabled. Stay PEND.
- Watchdog (TIMEOUT_CYCLES!=0): increments each PEND cycle without ack. When it equals TIMEOUT_CYCLES-1 with no ack: o_irq<=0, o_timeout<=1, go IDLE. Ack in that same cycle takes priority; o_timeout not set.
- i_enable=0: synchronous return to IDLE, o_irq<=0, events dropped (edge flop still tracks input). Snapshot, seq and flags hold.
- i_clr_flags: clears o_overrun/o_timeout/counter. A set condition in the same cycle wins (flag ends 1).
- o_busy = (state==PEND).

Optional Feature:
BOTUPD_OVERRUN_CNT_EN: defined -> adds output o_overrun_cnt [CNT_W-1:0], reset 0. It counts overrun events and saturates at all-ones (no wrap); it is cleared by i_clr_flags, and set-wins also applies to increments. Undefined -> port and counter absent; only the sticky o_overrun exists.

Test Plan:
- Reset, enable=1, i_bot_info=0x12345678, pulse upd 1 cycle -> next cycle o_irq=1, snap=0x12345678, seq=1, busy=1; ack 1 cycle -> o_irq=0, IDLE.
- upd held high 10 cycles, then ack -> exactly one capture (seq=1). A second rising edge after ack -> seq=2.
- In PEND, change info to 0xAAAA5555 and pulse upd without ack -> snap unchanged, o_overrun=1, o_overrun_cnt=1 (macro on). Three more -> cnt=4. With CNT_W=2, 5 overruns -> cnt stays 3.
- ack and upd in same cycle with info=0xDEADBEEF -> o_irq stays 1, snap=0xDEADBEEF, seq incremented.
- TIMEOUT_CYCLES=16, event with no ack -> o_irq drops 16 cycles after entering PEND, o_timeout=1. clr_flags -> o_timeout=0. Ack on the 16th cycle -> o_timeout stays 0.
- Assert rst while PEND -> o_irq=0 asynchronously, all outputs 0. enable=0 during PEND -> IDLE next cycle, events ignored.

Source files
------------

// File: rtl/bot_update_ctrl_if.sv
// -----------------------------------------------------------------------------
// bot_update_ctrl_if
// Bundles the bot-side and CPU-side signals of the Rojobot register-update /
// interrupt handshake so they travel as one port.
//
// Optional feature macro: BOTUPD_OVERRUN_CNT_EN
//   defined   -> adds parameter CNT_W and the o_overrun_cnt signal
//   undefined -> neither exists
//
// Signals (direction seen from the controller, i.e. the slave modport):
//   i_enable         in   1 = handshake active, 0 = ignore events, force IDLE
//   i_upd_sysregs    in   bot update strobe (level)
//   i_bot_info       in   live {LocX, LocY, Sensors, BotInfo}
//   i_int_ack        in   CPU acknowledge (level)
//   i_clr_flags      in   clears sticky overrun/timeout flags (and counter)
//   o_irq            out  interrupt request to the CPU
//   o_bot_info_snap  out  snapshot captured at the accepted event
//   o_upd_seq        out  capture sequence number, wraps 255 -> 0
//   o_overrun        out  sticky: event arrived while a request was pending
//   o_timeout        out  sticky: watchdog auto-cleared a request
//   o_busy           out  1 while a request is pending
//   o_dbg_state      out  raw FSM state (0 = IDLE, 1 = PEND)
//   o_overrun_cnt    out  saturating overrun count (macro only)
//
// Handshake: a request is raised by a rising edge of i_upd_sysregs and held on
// o_irq until i_int_ack is seen high in a PEND cycle, the watchdog expires, or
// i_enable drops; an ack seen while no request is pending has no effect.
// -----------------------------------------------------------------------------
interface bot_update_ctrl_if
`ifdef BOTUPD_OVERRUN_CNT_EN
    #(parameter int CNT_W = 8)
`endif
    ;
    logic        i_enable;
    logic        i_upd_sysregs;
    logic [31:0] i_bot_info;
    logic        i_int_ack;
    logic        i_clr_flags;
    logic        o_irq;
    logic [31:0] o_bot_info_snap;
    logic [7:0]  o_upd_seq;
    logic        o_overrun;
    logic        o_timeout;
    logic        o_busy;
    logic        o_dbg_state;
`ifdef BOTUPD_OVERRUN_CNT_EN
    logic [CNT_W-1:0] o_overrun_cnt;
`endif

    modport slave (
        input  i_enable, i_upd_sysregs, i_bot_info, i_int_ack, i_clr_flags,
        output o_irq, o_bot_info_snap, o_upd_seq, o_overrun, o_timeout,
               o_busy, o_dbg_state
`ifdef BOTUPD_OVERRUN_CNT_EN
        , output o_overrun_cnt
`endif
    );

    modport master (
        output i_enable, i_upd_sysregs, i_bot_info, i_int_ack, i_clr_flags,
        input  o_irq, o_bot_info_snap, o_upd_seq, o_overrun, o_timeout,
               o_busy, o_dbg_state
`ifdef BOTUPD_OVERRUN_CNT_EN
        , input o_overrun_cnt
`endif
    );
endinterface

// File: rtl/bot_update_ctrl.sv
// -----------------------------------------------------------------------------
// bot_update_ctrl
// Sequences the Rojobot register-update / CPU interrupt handshake. Each rising
// edge of upd_sysregs captures a coherent snapshot of the BotInfo word and
// raises an interrupt that is held until the CPU acknowledges it or the
// watchdog expires.
//
// Optional feature macro: BOTUPD_OVERRUN_CNT_EN (adds CNT_W and a saturating
// overrun counter on bus.o_overrun_cnt).
//
// Parameters:
//   TIMEOUT_CYCLES  PEND cycles without ack before auto-clear, 0 = no watchdog
//   CNT_W           overrun counter width (macro only)
//
// Ports:
//   clk   block clock
//   rst   asynchronous reset, active-high
//   bus   bot_update_ctrl_if.slave, see the interface header for signals
// -----------------------------------------------------------------------------
module bot_update_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
`ifdef BOTUPD_OVERRUN_CNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    bot_update_ctrl_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state;
    logic        upd_prev;
    logic [31:0] wd_cnt;
    logic        irq_q;
    logic [31:0] snap_q;
    logic [7:0]  seq_q;
    logic        overrun_q;
    logic        timeout_q;

    logic        upd_evt;
    logic        wd_expire;
    logic        ovr_set;
    logic        to_set;

    // A level held high produces a single event.
    assign upd_evt   = bus.i_upd_sysregs & ~upd_prev;
    assign wd_expire = (TIMEOUT_CYCLES != 32'd0) &&
                       (wd_cnt == TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        ovr_set = 1'b0;
        to_set  = 1'b0;
        if (bus.i_enable && (state == PEND) && !bus.i_int_ack) begin
            ovr_set = upd_evt;
            to_set  = wd_expire;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            upd_prev  <= 1'b0;
            wd_cnt    <= 32'd0;
            irq_q     <= 1'b0;
            snap_q    <= 32'd0;
            seq_q     <= 8'd0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // The edge detector keeps tracking even while disabled so that
            // re-enabling with the strobe already high is not an event.
            upd_prev <= bus.i_upd_sysregs;

            if (!bus.i_enable) begin
                state  <= IDLE;
                irq_q  <= 1'b0;
                wd_cnt <= 32'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (upd_evt) begin
                            snap_q <= bus.i_bot_info;
                            seq_q  <= seq_q + 8'd1;
                            irq_q  <= 1'b1;
                            wd_cnt <= 32'd0;
                            state  <= PEND;
                        end
                    end
                    PEND: begin
                        if (bus.i_int_ack && upd_evt) begin
                            // Ack closes the old request and a new one opens in
                            // the same cycle; the new seq tells them apart.
                            snap_q <= bus.i_bot_info;
                            seq_q  <= seq_q + 8'd1;
                            irq_q  <= 1'b1;
                            wd_cnt <= 32'd0;
                        end else if (bus.i_int_ack) begin
                            irq_q  <= 1'b0;
                            wd_cnt <= 32'd0;
                            state  <= IDLE;
                        end else if (wd_expire) begin
                            irq_q  <= 1'b0;
                            wd_cnt <= 32'd0;
                            state  <= IDLE;
                        end else begin
                            // Snapshot is deliberately left alone on an
                            // un-acked event so the CPU reads a coherent word.
                            wd_cnt <= wd_cnt + 32'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // Set wins over clear.
            overrun_q <= ovr_set | (overrun_q & ~bus.i_clr_flags);
            timeout_q <= to_set  | (timeout_q & ~bus.i_clr_flags);
        end
    end

`ifdef BOTUPD_OVERRUN_CNT_EN
    logic [CNT_W-1:0] ovr_cnt_q;

    // Clear and increment in the same cycle leaves a count of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_cnt_q <= '0;
        end else if (bus.i_clr_flags) begin
            ovr_cnt_q <= ovr_set ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (ovr_set && (ovr_cnt_q != {CNT_W{1'b1}})) begin
            ovr_cnt_q <= ovr_cnt_q + 1'b1;
        end
    end

    assign bus.o_overrun_cnt = ovr_cnt_q;
`endif

    assign bus.o_irq           = irq_q;
    assign bus.o_bot_info_snap = snap_q;
    assign bus.o_upd_seq       = seq_q;
    assign bus.o_overrun       = overrun_q;
    assign bus.o_timeout       = timeout_q;
    assign bus.o_busy          = (state == PEND);
    assign bus.o_dbg_state     = state;

endmodule

// File: tb/tb_bot_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bot_update_ctrl
// Directed scenarios followed by random stimulus, all compared every cycle
// against a request-level reference model. Captured snapshots are queued and
// matched whenever the DUT sequence number moves.
// -----------------------------------------------------------------------------
module tb_bot_update_ctrl;

    localparam logic [31:0] TB_TIMEOUT = 32'd16;
    localparam int          TB_CNT_W   = 3;

    logic clk;
    logic rst;

`ifdef BOTUPD_OVERRUN_CNT_EN
    bot_update_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();
    bot_update_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    bot_update_ctrl_if bus ();
    bot_update_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  last_seq;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks whether a request is outstanding and how long it has waited;
    // the request times out once it has waited TB_TIMEOUT un-acked cycles.
    logic        m_pend;
    logic        m_prev;
    int          m_wait;
    logic [31:0] m_snap;
    int          m_seq;
    logic        m_ovr;
    logic        m_to;
    int          m_cnt;

    task automatic model_reset();
        m_pend = 1'b0; m_prev = 1'b0; m_wait = 0; m_snap = 32'd0;
        m_seq = 0; m_ovr = 1'b0; m_to = 1'b0; m_cnt = 0;
        exp_q.delete();
        last_seq = 8'd0;
    endtask

    task automatic model_capture();
        m_snap = bus.i_bot_info;
        m_seq  = (m_seq + 1) % 256;
        m_pend = 1'b1;
        m_wait = 0;
        exp_q.push_back(bus.i_bot_info);
    endtask

    task automatic model_update();
        logic ev;
        logic set_ovr;
        logic set_to;
        ev      = bus.i_upd_sysregs && !m_prev;
        m_prev  = bus.i_upd_sysregs;
        set_ovr = 1'b0;
        set_to  = 1'b0;
        if (!bus.i_enable) begin
            m_pend = 1'b0;
        end else if (!m_pend) begin
            if (ev) model_capture();
        end else if (bus.i_int_ack) begin
            if (ev) model_capture();
            else    m_pend = 1'b0;
        end else begin
            set_ovr = ev;
            m_wait++;
            if (m_wait == int'(TB_TIMEOUT)) begin
                m_pend = 1'b0;
                set_to = 1'b1;
            end
        end
        if (set_ovr)               m_ovr = 1'b1;
        else if (bus.i_clr_flags)  m_ovr = 1'b0;
        if (set_to)                m_to = 1'b1;
        else if (bus.i_clr_flags)  m_to = 1'b0;
        if (bus.i_clr_flags)                          m_cnt = set_ovr ? 1 : 0;
        else if (set_ovr && m_cnt < (1 << TB_CNT_W) - 1) m_cnt++;
    endtask

    task automatic compare_all();
        check("irq",     {31'd0, bus.o_irq},     {31'd0, m_pend});
        check("busy",    {31'd0, bus.o_busy},    {31'd0, m_pend});
        check("snap",    bus.o_bot_info_snap,    m_snap);
        check("seq",     {24'd0, bus.o_upd_seq}, m_seq);
        check("overrun", {31'd0, bus.o_overrun}, {31'd0, m_ovr});
        check("timeout", {31'd0, bus.o_timeout}, {31'd0, m_to});
`ifdef BOTUPD_OVERRUN_CNT_EN
        check("ovr_cnt", {{(32-TB_CNT_W){1'b0}}, bus.o_overrun_cnt}, m_cnt);
`endif
        if (bus.o_upd_seq != last_seq) begin
            if (exp_q.size() == 0)
                check("seq_unexpected", {24'd0, bus.o_upd_seq}, {24'd0, last_seq});
            else
                check("snap_q", bus.o_bot_info_snap, exp_q.pop_front());
            last_seq = bus.o_upd_seq;
        end
    endtask

    // ---------------- driver ----------------
    // Entered and left at a falling edge.
    task automatic step(input logic en, input logic upd, input logic [31:0] info,
                        input logic ack, input logic clr);
        bus.i_enable      = en;
        bus.i_upd_sysregs = upd;
        bus.i_bot_info    = info;
        bus.i_int_ack     = ack;
        bus.i_clr_flags   = clr;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        bus.i_enable = 1'b0; bus.i_upd_sysregs = 1'b0; bus.i_bot_info = 32'd0;
        bus.i_int_ack = 1'b0; bus.i_clr_flags = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_irq",  {31'd0, bus.o_irq}, 32'd0);
        check("rst_snap", bus.o_bot_info_snap, 32'd0);
        check("rst_seq",  {24'd0, bus.o_upd_seq}, 32'd0);
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("rst_flags", {30'd0, bus.o_overrun, bus.o_timeout}, 32'd0);

        // Single pulse then ack
        step(1, 1, 32'h12345678, 0, 0);
        check("t1_irq",  {31'd0, bus.o_irq}, 32'd1);
        check("t1_snap", bus.o_bot_info_snap, 32'h12345678);
        check("t1_seq",  {24'd0, bus.o_upd_seq}, 32'd1);
        check("t1_busy", {31'd0, bus.o_busy}, 32'd1);
        step(1, 0, 32'h12345678, 1, 0);
        check("t1_ack_irq", {31'd0, bus.o_irq}, 32'd0);
        check("t1_ack_state", {31'd0, bus.o_dbg_state}, 32'd0);

        // Level held high is one event
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, 32'h12345678, 0, 0);
        step(1, 0, 32'h12345678, 1, 0);
        check("t2_seq", {24'd0, bus.o_upd_seq}, 32'd1);
        check("t2_irq", {31'd0, bus.o_irq}, 32'd0);
        step(1, 1, 32'h12345678, 0, 0);
        check("t2_seq2", {24'd0, bus.o_upd_seq}, 32'd2);

        // Overrun while pending keeps the snapshot
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'hAAAA5555, 0, 0);
            step(1, 1, 32'hAAAA5555, 0, 0);
            check("t3_snap", bus.o_bot_info_snap, 32'h12345678);
            check("t3_ovr",  {31'd0, bus.o_overrun}, 32'd1);
`ifdef BOTUPD_OVERRUN_CNT_EN
            check("t3_cnt", {{(32-TB_CNT_W){1'b0}}, bus.o_overrun_cnt}, i + 1);
`endif
        end

        // Ack and event together re-arm with the new word
        step(1, 0, 32'hDEADBEEF, 0, 0);
        step(1, 1, 32'hDEADBEEF, 1, 0);
        check("t4_irq",  {31'd0, bus.o_irq}, 32'd1);
        check("t4_snap", bus.o_bot_info_snap, 32'hDEADBEEF);
        check("t4_seq",  {24'd0, bus.o_upd_seq}, 32'd3);

        // Counter saturates at all-ones
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'h0, 0, 0);
            step(1, 1, 32'h0, 0, 0);
        end
`ifdef BOTUPD_OVERRUN_CNT_EN
        check("t4_cnt_sat", {{(32-TB_CNT_W){1'b0}}, bus.o_overrun_cnt}, 32'd7);
`endif
        step(1, 0, 32'h0, 0, 1);
        check("t4_clr_ovr", {31'd0, bus.o_overrun}, 32'd0);
        step(1, 0, 32'h0, 1, 0);

        // Watchdog expiry
        step(1, 1, 32'h00000005, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            step(1, 0, 32'h00000005, 0, 0);
            if (k == 15) check("t5_irq_held", {31'd0, bus.o_irq}, 32'd1);
        end
        check("t5_irq_drop", {31'd0, bus.o_irq}, 32'd0);
        check("t5_timeout",  {31'd0, bus.o_timeout}, 32'd1);
        step(1, 0, 32'h0, 0, 1);
        check("t5_clr", {31'd0, bus.o_timeout}, 32'd0);

        // Ack on the last cycle beats the watchdog
        step(1, 1, 32'h00000006, 0, 0);
        for (int k = 1; k <= 15; k++) step(1, 0, 32'h00000006, 0, 0);
        check("t6_irq_held", {31'd0, bus.o_irq}, 32'd1);
        step(1, 0, 32'h00000006, 1, 0);
        check("t6_irq",     {31'd0, bus.o_irq}, 32'd0);
        check("t6_timeout", {31'd0, bus.o_timeout}, 32'd0);

        // Disable during PEND
        step(1, 1, 32'h00000007, 0, 0);
        step(0, 0, 32'h00000007, 0, 0);
        check("t7_irq",  {31'd0, bus.o_irq}, 32'd0);
        check("t7_busy", {31'd0, bus.o_busy}, 32'd0);
        step(0, 1, 32'h00000008, 0, 0);
        check("t7_drop", {31'd0, bus.o_irq}, 32'd0);
        step(1, 1, 32'h00000008, 0, 0);
        check("t7_held", {31'd0, bus.o_irq}, 32'd0);
        step(1, 0, 32'h00000008, 0, 0);

        // Asynchronous reset while pending
        step(1, 1, 32'h0BADF00D, 0, 0);
        check("t8_pend", {31'd0, bus.o_irq}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t8_irq",  {31'd0, bus.o_irq}, 32'd0);
        check("t8_busy", {31'd0, bus.o_busy}, 32'd0);
        check("t8_snap", bus.o_bot_info_snap, 32'd0);
        check("t8_seq",  {24'd0, bus.o_upd_seq}, 32'd0);
        bus.i_upd_sysregs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 15) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
